// File: rtl/ps2_key_digits_if.sv
// PS/2 pin pair and seven-segment nibble bus of ps2_key_digits.
// master: keyboard/pin side driving PS/2 lines and observing the digit nibbles.
// slave : receiver/key tracker consuming the PS/2 lines and driving the nibbles.
interface ps2_key_digits_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] scan_hi;
  logic [3:0] scan_lo;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       key_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  scan_hi, scan_lo, cnt_tens, cnt_ones, key_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_hi, scan_lo, cnt_tens, cnt_ones, key_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_digits.sv
// PS/2 keyboard receiver plus make/break key tracker feeding four 7-seg nibbles.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames must also carry odd parity.
module ps2_key_digits #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_key_digits_if.slave bus
);

  localparam int unsigned TO_W    = 17;
  localparam int unsigned FRAME_W = 10;
  localparam logic [7:0]  C_E0    = 8'hE0;
  localparam logic [7:0]  C_F0    = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_BREAK} state_t;

  logic               r_clk_s1, r_clk_s2, r_clk_hist;
  logic               r_dat_s1, r_dat_s2;
  logic               w_fall;
  logic [3:0]         r_bitcnt;
  logic [FRAME_W-1:0] r_frame;
  logic [TO_W-1:0]    r_to_cnt;
  logic               w_timeout;
  logic               w_frame_ok;
  logic               w_par_ok;
  logic               r_byte_valid;
  logic [7:0]         r_byte;
  logic               r_err_pulse;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_held, w_held_nxt;
  logic [3:0]         r_tens, w_tens_nxt;
  logic [3:0]         r_ones, w_ones_nxt;
  logic               r_kv, w_kv_nxt;
  logic               w_press;
  logic               r_frame_err;

  // Two-flop synchronisers plus one history flop on the PS/2 clock; idle-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= bus.ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= bus.ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_hist & ~r_clk_s2;
  assign w_timeout = (r_bitcnt != 4'd0) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  // r_frame holds start..parity (bit 0 = start) once ten bits have been shifted in.
`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^r_frame[9:1];
`else
  logic w_unused_par;
  assign w_unused_par = r_frame[9];
  assign w_par_ok     = 1'b1;
`endif
  assign w_frame_ok = ~r_frame[0] & r_dat_s2 & w_par_ok;

  // Bit capture, frame check at the stop bit, and inter-edge timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt     <= 4'd0;
      r_frame      <= '0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'h00;
      r_err_pulse  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_err_pulse  <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bitcnt == 4'd10) begin
          r_bitcnt     <= 4'd0;
          r_byte       <= r_frame[8:1];
          r_byte_valid <= w_frame_ok;
          r_err_pulse  <= ~w_frame_ok;
        end else begin
          r_frame  <= {r_dat_s2, r_frame[FRAME_W-1:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (w_timeout) begin
        r_bitcnt <= 4'd0;
        r_to_cnt <= '0;
      end else if (r_bitcnt != 4'd0) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Key tracker state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Key tracker next state: E0 prefixes are ignored everywhere.
  always_comb begin
    w_state_nxt = r_state;
    if (r_byte_valid && (r_byte != C_E0)) begin
      case (r_state)
        S_IDLE:    w_state_nxt = (r_byte == C_F0) ? S_BREAK : S_PRESSED;
        S_PRESSED: if (r_byte == C_F0) w_state_nxt = S_BREAK;
        S_BREAK: begin
          if (r_byte == r_held) w_state_nxt = S_IDLE;
          else                  w_state_nxt = r_kv ? S_PRESSED : S_IDLE;
        end
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Key tracker outputs: new press loads held code and bumps the BCD count.
  always_comb begin
    w_held_nxt = r_held;
    w_tens_nxt = r_tens;
    w_ones_nxt = r_ones;
    w_kv_nxt   = r_kv;
    w_press    = 1'b0;
    if (r_byte_valid && (r_byte != C_E0)) begin
      case (r_state)
        S_IDLE:    w_press = (r_byte != C_F0);
        S_PRESSED: w_press = (r_byte != C_F0) && (r_byte != r_held);
        S_BREAK:   if (r_byte == r_held) w_kv_nxt = 1'b0;
        default:   w_press = 1'b0;
      endcase
    end
    if (w_press) begin
      w_held_nxt = r_byte;
      w_kv_nxt   = 1'b1;
      if (r_ones == 4'd9) begin
        w_ones_nxt = 4'd0;
        w_tens_nxt = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
      end else begin
        w_ones_nxt = r_ones + 4'd1;
      end
    end
  end

  // Registered digit outputs and sticky frame error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held      <= 8'h00;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_kv        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_held      <= w_held_nxt;
      r_tens      <= w_tens_nxt;
      r_ones      <= w_ones_nxt;
      r_kv        <= w_kv_nxt;
      r_frame_err <= r_frame_err | r_err_pulse;
    end
  end

  assign bus.scan_hi   = r_held[7:4];
  assign bus.scan_lo   = r_held[3:0];
  assign bus.cnt_tens  = r_tens;
  assign bus.cnt_ones  = r_ones;
  assign bus.key_valid = r_kv;
  assign bus.frame_err = r_frame_err;

endmodule

// File: doc/ps2_key_digits.md
# ps2_key_digits

PS/2 keyboard receiver and key-tracking stage that produces the 4-bit nibbles consumed by the seven-segment decoders. It deserialises PS/2 frames from the keyboard pins, tracks make/break codes with a small FSM, and presents the held scancode plus a BCD key-press count as four nibbles, with a blanking qualifier, to four downstream decoder instances.

## Interface
- TIMEOUT_CYCLES, default 50000: idle clk cycles allowed between PS/2 clock falling edges inside a frame before the partial frame is discarded.
- clk  input  1  system clock; all state is in this domain.
- rst  input  1  reset, asynchronous, active-high.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- scan_hi  output  4  high nibble of the held scancode.
- scan_lo  output  4  low nibble of the held scancode.
- cnt_tens  output  4  BCD tens digit of the press count, 0-9.
- cnt_ones  output  4  BCD ones digit of the press count, 0-9.
- key_valid  output  1  1 while a key is held; downstream blanks the scancode digits when 0.
- frame_err  output  1  sticky flag for any malformed frame.

## Operation
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops; one extra history flop on ps2_clk. A falling edge is detected when history=1 and synced clock=0.
- Receiver: on each detected falling edge, the synced ps2_data is sampled into an 11-bit frame. Frame order: start(0), d0..d7 (LSB first), odd parity, stop(1). A bit counter runs 0..10 and wraps to 0 after the stop bit.
- Frame check at stop bit: start==0 and stop==1 (plus parity, see Configuration). If the frame passes, byte_valid pulses for 1 cycle with the byte. If it fails, no pulse is produced and frame_err is set.
- Timeout: a 17-bit counter is cleared on every falling edge and runs while the bit counter is nonzero. When it reaches TIMEOUT_CYCLES, the bit counter is forced to 0, the partial frame is dropped, and frame_err is not set.
- Decoder FSM states: IDLE, PRESSED, BREAK. Held code register: held[7:0].
  - IDLE with byte E0: ignored. Byte F0: go to BREAK. Any other byte X: held=X, count+=1, key_valid=1, go to PRESSED.
  - PRESSED with byte E0: ignored. Byte F0: go to BREAK. Byte == held (typematic repeat): no change. Other byte X: held=X, count+=1, stay in PRESSED.
  - BREAK with byte E0: ignored, stay in BREAK. Byte == held: key_valid=0, go to IDLE. Other byte: discarded; return to PRESSED if key_valid=1, else IDLE.
- Count: 2-digit BCD, ones digit 9→0 carries into tens; count 99 + 1 wraps to 00.
- scan_hi/scan_lo = held[7:4]/held[3:0]. held keeps its value after release, and key_valid qualifies it.
- Reset values: all outputs 0, held=00, count=00, FSM=IDLE, bit counter=0, timeout counter=0, synchronisers=1 (line idle high).

## Timing
- Edge detect: 3 clk cycles from a raw ps2_clk fall to detection (2 sync + history).
- Let T be the cycle in which the stop-bit falling edge is detected. byte_valid is high in cycle T+1. FSM state and all outputs update at the clk edge ending T+1 and are visible in cycle T+2.
- frame_err rises at the same point a byte_valid would have (T+2). It is cleared only by rst.
- A falling edge and a timeout expiring in the same cycle: the falling edge wins; the bit is captured and the counter is cleared.
- rst mid-frame takes effect immediately. The receiver restarts at the next start bit, and no partial byte is delivered.

## Configuration
- PS2_PARITY_CHECK_EN defined: the frame must also satisfy odd parity over d0..d7 plus the parity bit. A mismatch drops the byte and sets frame_err.
- PS2_PARITY_CHECK_EN undefined: the parity bit is sampled but ignored, and only start/stop are checked.

## Test plan
- Send frame 0x1C (A) -> held=1C, scan_hi=1, scan_lo=C, key_valid=1, count=01 at T+2.
- Send 0x1C three more times (typematic), then F0 1C -> count stays 01; key_valid=0 after the final byte; scan still 1C.
- Send 100 press/release pairs of 0x1C starting from reset -> count reads 99 after the 99th press and 00 after the 100th.
- With PS2_PARITY_CHECK_EN: send 0x1C with even parity -> no state change, frame_err=1. Without the macro -> press accepted, frame_err=0.
- Send 5 bits, stall TIMEOUT_CYCLES+10 cycles, then send full frame 0x32 -> held=32, count=01, frame_err=0.
- Send E0 75 then F0 75 -> held=75, count=01, key_valid ends at 0; assert rst mid-frame -> all outputs 0 within the same cycle.
